// File: rtl/bcd_digit_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first, decimal carry rippled through a register.
// Optional operand-digit validity flag is built only when BCD_INVALID_CHECK_EN is defined.
module bcd_digit_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [4:0]       t;
    logic [3:0]       digit;
    logic             carry_next;
    logic [W-1:0]     res_next;
    logic             accept;
    logic             last;

    // One-digit decimal correction; invalid digits follow the same rule.
    always_comb begin
        t          = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
        digit      = t[3:0];
        carry_next = 1'b0;
        if (t > 5'd9) begin
            digit      = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        res_next          = res >> 4;
        res_next[W-1 -: 4] = digit;
    end

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (idx == IDX_W'(DIGITS - 1));

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                        res   <= '0;
                        state <= S_ADD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    carry <= carry_next;
                    res   <= res_next;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= carry_next;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    logic bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad = 1'b1;
            end
        end
    end

    // Flag is captured with the operands and held alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= bad;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_serial_adder.sv
// Directed, table-driven bench for bcd_digit_serial_adder (DIGITS=4) plus hand-written handshake/reset sequences.
module tb_bcd_digit_serial_adder;

    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        bad;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        cin   = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int checks = 0;
    int passes = 0;

    vec_t vecs[9];

    bcd_digit_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic exp_err(input logic bad);
`ifdef BCD_INVALID_CHECK_EN
        return bad;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after the bound).
    task automatic run_op(input vec_t v, input string name);
        int busy_cnt = 0;
        int done_at  = 0;
        int overlap  = 0;
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a     = 16'($urandom);
                b     = 16'($urandom);
                cin   = 1'($urandom);
                chk({name, "_err_at_start"}, 32'(err), 32'(exp_err(v.bad)));
            end
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done) done_at = n;
        end
        chk({name, "_latency"},  32'(done_at),  32'(DIGITS + 1));
        chk({name, "_busy_cyc"}, 32'(busy_cnt), 32'(DIGITS));
        chk({name, "_overlap"},  32'(overlap),  32'd0);
        chk({name, "_sum"},      32'(sum),      32'(v.sum));
        chk({name, "_cout"},     32'(cout),     32'(v.cout));
        chk({name, "_err"},      32'(err),      32'(exp_err(v.bad)));
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[5] = '{16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1};
        vecs[7] = '{16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Result held through idle.
        repeat (3) @(negedge clk);
        chk("hold_sum",  32'(sum),  32'(vecs[8].sum));
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_done", 32'(done), 32'd0);

        // Back-to-back with start held through ADD and DONE.
        start = 1'b1; a = 16'h0005; b = 16'h0005; cin = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) begin a = 16'h4321; b = 16'h1111; end
            if (n == 5) begin
                chk("b2b_done1", 32'(done), 32'd1);
                chk("b2b_sum1",  32'(sum),  32'h0010);
            end
            if (n == 6) begin
                start = 1'b0;
                chk("b2b_busy2", 32'(busy), 32'd1);
                chk("b2b_nodone", 32'(done), 32'd0);
            end
            if (n == 10) begin
                chk("b2b_done2", 32'(done), 32'd1);
                chk("b2b_sum2",  32'(sum),  32'h5432);
            end
            if (n == 11) chk("b2b_done_pulse", 32'(done), 32'd0);
        end
        @(negedge clk);

        // Start pulse during ADD must be ignored.
        start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 2) begin start = 1'b1; a = 16'h9999; b = 16'h0001; end
            if (n == 3) start = 1'b0;
            if (n == 5) begin
                chk("ign_done", 32'(done), 32'd1);
                chk("ign_sum",  32'(sum),  32'h6912);
            end
            if (n == 6) begin
                chk("ign_busy", 32'(busy), 32'd0);
                chk("ign_done_after", 32'(done), 32'd0);
            end
        end

        // Reset on the second ADD cycle aborts the operation.
        start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run_op(vecs[0], "after_abort");
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/bcd_digit_serial_adder.md
# bcd_digit_serial_adder

Digit-serial multi-digit BCD adder that adds two packed BCD operands one 4-bit digit per clock, least-significant digit first, rippling the decimal carry through a register between cycles. It sits downstream of the operand source, such as a keypad or register file, and upstream of display/result logic. It reuses the team's one-digit correction rule: add 6 when the binary digit sum exceeds 9. A start/done handshake frames each operation; results stay held until the next accepted start.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on clk edge in IDLE or DONE
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- b  input  4*DIGITS  operand B, packed BCD
- cin  input  1  decimal carry-in into digit 0
- busy  output  1  high while digits are being processed (ADD state)
- done  output  1  one-cycle pulse, result valid
- sum  output  4*DIGITS  registered packed BCD result
- cout  output  1  decimal carry out of the top digit
- err  output  1  any operand digit > 9 (see Configuration)

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - start=1 → latch a, b, cin into internal shift/carry registers; clear digit index; clear err; go to ADD.
  - start=0 → stay in IDLE.
- ADD: each cycle processes digit idx:
  - t = a_d + b_d + c, 5-bit.
  - If t > 9: digit = (t + 6)[3:0], c_next = 1.
  - Else: digit = t[3:0], c_next = 0.
  - Shift digit into the result register from the top. Increment idx.
  - After digit DIGITS-1: load sum and cout, go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → accept a new operation immediately (same actions as IDLE), go to ADD.
  - Otherwise → IDLE.
- start in ADD is ignored: no queuing, operands unchanged.
- Inputs a, b, cin are don't-care except at the accepting edge.
- Invalid digits (>9) follow the same rule deterministically, e.g. 15+15+1=31 → digit 5, carry 1.
- sum, cout and err hold their values through IDLE until the next operation completes. err is the exception: it is cleared at the next accepted start.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0, state IDLE, internal registers 0.
- Reset mid-operation aborts the operation, returns to IDLE and clears all outputs. No done is produced for the aborted operation.
- start accepted at edge k:
  - busy=1 from after edge k until edge k+DIGITS.
  - sum/cout update at edge k+DIGITS.
  - done=1 for the cycle between edges k+DIGITS and k+DIGITS+1.
- Latency: start → done = DIGITS+1 cycles.
- Throughput: back-to-back with start held through DONE, one result every DIGITS+1 cycles.
- busy and done are never high together.
- done is Moore, decoded from state only.

## Configuration
- BCD_INVALID_CHECK_EN defined:
  - At the accepting edge, err is set if any digit of a or b exceeds 9.
  - err is held with the result and cleared on the next accepted start.
  - The addition still completes per the rule above.
- Not defined: err is tied 0 and no check logic is built. Behaviour is otherwise identical.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse → done 5 cycles later; sum=0x6912, cout=0, busy high exactly 4 cycles.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Then a=0x0999, b=0x0000, cin=1 → sum=0x1000, cout=0.
- Hold start=1 with a new operand each acceptance: 0x0005+0x0005 then 0x4321+0x1111 → done pulses 5 cycles apart, sum=0x0010 then 0x5432. A start pulse mid-ADD is ignored.
- Assert rst on the 2nd ADD cycle of 0x1234+0x5678 → immediately busy=0, sum=0, cout=0. No done until a new start, which yields the correct result.
- With BCD_INVALID_CHECK_EN: a=0x00A0, b=0x0000 → err=1 with done, sum=0x0100. The next valid operation clears err at its start edge. Without the macro, err stays 0 and the same sum is produced.
